pipe_stage_reg: RTL and testbench

//  Parametrised pipeline stage register for the IF/ID/EX/MEM/WB boundaries.

---
 rtl/pipe_stage_reg.sv | 128 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, synchronous flush and an
// optional 2-entry skid buffer that makes in_ready a registered signal.
module pipe_stage_reg #(
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 4,
    parameter int CTRL_W   = 9,
    parameter int RD_W     = 5,
    parameter int SKID     = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [RD_W-1:0]            in_rd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [RD_W-1:0]            out_rd,
    output logic [1:0]                 occupancy
);

    localparam int DW = NUM_DATA * DATA_W;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL2 = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       main_data_q, main_data_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [RD_W-1:0]     main_rd_q, main_rd_d;
    logic [DW-1:0]       skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [RD_W-1:0]     skid_rd_q, skid_rd_d;
    logic                in_fire;
    logic                out_fire;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (SKID != 0) ? (state_q != FULL2) : (!out_valid || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign out_data  = main_data_q;
    assign out_rd    = main_rd_q;
    // A bubble must never look like a write or a branch downstream.
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign occupancy = state_q;

    always_comb begin
        // NOTE: every variable gets a hold default first so no path can infer a latch.
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        main_rd_d   = main_rd_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_rd_d   = skid_rd_q;

        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        main_rd_d   = in_rd;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        main_rd_d   = in_rd;
                    end else if (in_fire && (SKID != 0)) begin
                        // Main is stalled; the newcomer waits behind it so order is kept.
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        skid_rd_d   = in_rd;
                        state_d     = FULL2;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL2: begin
                    if (out_fire) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        main_rd_d   = skid_rd_q;
                        state_d     = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: payload registers are reset too, so outputs read 0 and no stale entry survives reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            main_rd_q   <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_rd_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            main_rd_q   <= main_rd_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_rd_q   <= skid_rd_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a SKID=1 instance for most scenarios and a
// SKID=0 instance for the combinational-ready mode.
module tb_pipe_stage_reg;

    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    int            checks = 0;
    int            errors = 0;

    // SKID=1 instance signals
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [8:0]    in_ctrl = '0;
    logic [4:0]    in_rd = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [8:0]    out_ctrl;
    logic [4:0]    out_rd;
    logic [1:0]    occupancy;

    // SKID=0 instance signals
    logic          flush_b = 1'b0;
    logic          in_valid_b = 1'b0;
    logic          in_ready_b;
    logic [DW-1:0] in_data_b = '0;
    logic [8:0]    in_ctrl_b = '0;
    logic [4:0]    in_rd_b = '0;
    logic          out_valid_b;
    logic          out_ready_b = 1'b0;
    logic [DW-1:0] out_data_b;
    logic [8:0]    out_ctrl_b;
    logic [4:0]    out_rd_b;
    logic [1:0]    occupancy_b;

    always #5 clk = ~clk;

    pipe_stage_reg #(.SKID(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_ctrl(in_ctrl), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .out_rd(out_rd), .occupancy(occupancy)
    );

    pipe_stage_reg #(.SKID(0)) dut_b (
        .clk(clk), .reset(reset), .flush(flush_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .in_ctrl(in_ctrl_b), .in_rd(in_rd_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_ctrl(out_ctrl_b), .out_rd(out_rd_b), .occupancy(occupancy_b)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Distinct value in every word so a word swap or truncation is visible.
    function automatic logic [DW-1:0] mk(input logic [31:0] w0);
        return {w0 + 32'h3000_0000, w0 + 32'h2000_0000, w0 + 32'h1000_0000, w0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w0, input logic [8:0] c, input logic [4:0] r);
        in_valid = 1'b1;
        in_data  = mk(w0);
        in_ctrl  = c;
        in_rd    = r;
    endtask

    logic [31:0] q[$];
    int          sent;
    int          recv;
    int          exp_occ;
    logic        exp_rdy;
    logic        of;
    logic        inf;

    initial begin
        // Reset and release
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_occ", occupancy, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_out_data", out_data, 0);

        // Streaming at full rate: latency 1, no bubbles, occupancy 1
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(32'h100 + i, 9'(i), 5'(i));
            tick();
            check($sformatf("stream_valid%0d", i), out_valid, 1);
            check($sformatf("stream_data%0d", i), out_data, mk(32'h100 + i));
            check($sformatf("stream_rd%0d", i), out_rd, 5'(i));
            check($sformatf("stream_occ%0d", i), occupancy, 1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain_valid", out_valid, 0);
        check("stream_drain_occ", occupancy, 0);

        // Control is visible only while valid
        send(32'h55, 9'h1FF, 5'd3);
        tick();
        check("ctrl_valid", out_ctrl, 9'h1FF);
        check("ctrl_rd", out_rd, 5'd3);
        in_valid = 1'b0;
        tick();
        check("ctrl_bubble_valid", out_valid, 0);
        check("ctrl_bubble_zero", out_ctrl, 0);

        // Backpressure fills the skid entry; release drains in order
        out_ready = 1'b0;
        send(32'hA, 9'h01, 5'd10);
        tick();
        send(32'hB, 9'h02, 5'd11);
        tick();
        check("bp_occ2", occupancy, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_hold_a", out_data, mk(32'hA));
        send(32'hEE, 9'h03, 5'd12);
        tick();
        check("bp_still_occ2", occupancy, 2);
        check("bp_still_a", out_data, mk(32'hA));
        check("bp_ctrl_a", out_ctrl, 9'h01);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_then_b", out_data, mk(32'hB));
        check("bp_ctrl_b", out_ctrl, 9'h02);
        check("bp_rd_b", out_rd, 5'd11);
        check("bp_occ1", occupancy, 1);
        tick();
        check("bp_empty_valid", out_valid, 0);
        check("bp_empty_occ", occupancy, 0);

        // Flush in FULL2 with a concurrent incoming entry
        out_ready = 1'b0;
        send(32'hA, 9'h01, 5'd1);
        tick();
        send(32'hB, 9'h02, 5'd2);
        tick();
        check("fl_pre_occ", occupancy, 2);
        flush = 1'b1;
        send(32'hC, 9'h04, 5'd3);
        tick();
        check("fl_valid", out_valid, 0);
        check("fl_occ", occupancy, 0);
        check("fl_ctrl", out_ctrl, 0);
        check("fl_in_ready", in_ready, 1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("fl_no_ghost", out_valid, 0);
        send(32'hD, 9'h05, 5'd4);
        tick();
        check("fl_next_data", out_data, mk(32'hD));
        check("fl_next_ctrl", out_ctrl, 9'h05);
        in_valid = 1'b0;
        tick();
        check("fl_next_gone", out_valid, 0);

        // Asynchronous reset while two entries are held
        out_ready = 1'b0;
        send(32'h1, 9'h0F, 5'd5);
        tick();
        send(32'h2, 9'h0E, 5'd6);
        tick();
        check("ar_pre_occ", occupancy, 2);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_ctrl", out_ctrl, 0);
        check("ar_occ", occupancy, 0);
        tick();
        reset = 1'b0;
        #1;
        check("ar_in_ready", in_ready, 1);
        out_ready = 1'b1;
        tick();
        check("ar_no_stale", out_valid, 0);
        out_ready = 1'b0;

        // SKID=0: out_ready toggles every cycle; ready is combinational
        sent    = 0;
        recv    = 0;
        exp_occ = 0;
        for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
            out_ready_b = (cyc % 2 == 0);
            in_valid_b  = (sent < 8);
            in_data_b   = mk(32'h200 + sent);
            in_ctrl_b   = 9'(sent + 1);
            #1;
            exp_rdy = (exp_occ == 0) || out_ready_b;
            check($sformatf("s0_in_ready%0d", cyc), in_ready_b, exp_rdy);
            check($sformatf("s0_valid%0d", cyc), out_valid_b, exp_occ != 0);
            of  = (exp_occ != 0) && out_ready_b;
            inf = in_valid_b && exp_rdy;
            if (of && q.size() > 0) begin
                check($sformatf("s0_order%0d", recv), out_data_b, mk(q[0]));
                void'(q.pop_front());
                recv++;
            end
            if (inf) begin
                q.push_back(32'h200 + sent);
                sent++;
            end
            exp_occ = inf ? 1 : (of ? 0 : exp_occ);
            @(posedge clk);
            #1;
            check($sformatf("s0_occ%0d", cyc), occupancy_b, 2'(exp_occ));
        end
        check("s0_all_received", recv, 8);
        in_valid_b = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
